repetition_scrubber: RTL and testbench

Repetition-protected register storage with a background scrubber. Each write stores REPETITION copies of the data word. Reads return the bitwise-majority-corrected word plus an error flag. A scrub FSM periodically re-reads one entry, checks it with a `repetition_checker` instance, and writes back the corrected copies. It sits between a requester that holds long-lived configuration or state and the replicated storage, and sequences detection and repair without stalling the requester.

---
 rtl/repetition_scrubber_pkg.sv | 18 +
 rtl/repetition_checker.sv | 13 +
 rtl/repetition_majority_voter.sv | 22 ++
 rtl/repetition_scrubber.sv | 154 +++++++++++++++
 tb/tb_repetition_scrubber.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/repetition_scrubber_pkg.sv
// Shared types and sizing helpers for the repetition-protected store and its scrubber.
package repetition_scrubber_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SCRUB_READ  = 2'd1,
    SCRUB_CHECK = 2'd2,
    SCRUB_WRITE = 2'd3
  } scrub_state_e;

  localparam int DEFAULT_DEPTH = 16;
  localparam int ADDRESS_WIDTH = $clog2(DEFAULT_DEPTH);

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/repetition_checker.sv
// Flags a stored block whose copies are not all identical.
module repetition_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int REPETITION = 3
) (
  input  logic [REPETITION*DATA_WIDTH-1:0] block_i,
  output logic                             error_o
);

  // Any copy differing from copy 0 means at least one bit position disagrees.
  assign error_o = |(block_i ^ {REPETITION{block_i[DATA_WIDTH-1:0]}});

endmodule

// File: rtl/repetition_majority_voter.sv
// Bitwise majority vote across REPETITION copies of a word.
module repetition_majority_voter #(
  parameter int DATA_WIDTH = 8,
  parameter int REPETITION = 3
) (
  input  logic [REPETITION*DATA_WIDTH-1:0] block_i,
  output logic [DATA_WIDTH-1:0]            word_o
);

  localparam int CNT_W = $clog2(REPETITION + 1);

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    logic [CNT_W-1:0] ones;
    always_comb begin
      ones = '0;
      for (int r = 0; r < REPETITION; r++)
        ones = ones + CNT_W'(block_i[r*DATA_WIDTH+b]);
    end
    assign word_o[b] = (ones > CNT_W'(REPETITION / 2));
  end

endmodule

// File: rtl/repetition_scrubber.sv
// Replicated flop storage with majority-voted reads and a background scrub FSM
// that repairs disagreeing entries in the gaps between user accesses.
module repetition_scrubber
  import repetition_scrubber_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int REPETITION     = 3,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 256,
  parameter int COUNT_WIDTH    = 8,
  localparam int AW            = addr_width(DEPTH),
  localparam int BW            = REPETITION * DATA_WIDTH
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   write_enable_i,
  input  logic [AW-1:0]          write_address_i,
  input  logic [DATA_WIDTH-1:0]  write_data_i,
  input  logic                   read_enable_i,
  input  logic [AW-1:0]          read_address_i,
  output logic [DATA_WIDTH-1:0]  read_data_o,
  output logic                   read_valid_o,
  output logic                   read_error_o,
  input  logic                   inject_enable_i,
  input  logic [AW-1:0]          inject_address_i,
  input  logic [BW-1:0]          inject_block_i,
  input  logic                   scrub_enable_i,
  output logic                   scrub_busy_o,
  output logic                   scrub_wrap_o,
  output logic [COUNT_WIDTH-1:0] error_count_o,
  input  logic                   error_count_clear_i
);

  localparam int IW = $clog2(SCRUB_INTERVAL);
  localparam logic [AW-1:0] LAST_ADDR     = AW'(DEPTH - 1);
  localparam logic [IW-1:0] INTERVAL_LAST = IW'(SCRUB_INTERVAL - 1);

  logic [DEPTH-1:0][BW-1:0] mem_q;
  logic [BW-1:0]            scrub_block_q;
  logic [AW-1:0]            scrub_addr_q;
  logic [IW-1:0]            interval_q, interval_d;
  logic                     stale_q, stale_d;
  scrub_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]    read_data_q;
  logic                     read_valid_q, read_error_q, wrap_q;
  logic [COUNT_WIDTH-1:0]   count_q;

  logic                  user_wr, scrub_hit, stale_now;
  logic [AW-1:0]         user_wr_addr;
  logic [DATA_WIDTH-1:0] rd_word, scrub_word;
  logic                  rd_err, scrub_err;
  logic                  latch_en, wb_en, advance;

  assign user_wr      = write_enable_i | inject_enable_i;
  assign user_wr_addr = inject_enable_i ? inject_address_i : write_address_i;
  assign scrub_hit    = user_wr && (user_wr_addr == scrub_addr_q);
  // A user write landing in the write-back cycle itself also invalidates the vote.
  assign stale_now    = stale_q | scrub_hit;

  repetition_majority_voter #(.DATA_WIDTH(DATA_WIDTH), .REPETITION(REPETITION)) u_rd_voter (
    .block_i(mem_q[read_address_i]), .word_o(rd_word));
  repetition_majority_voter #(.DATA_WIDTH(DATA_WIDTH), .REPETITION(REPETITION)) u_scrub_voter (
    .block_i(scrub_block_q), .word_o(scrub_word));
  repetition_checker #(.DATA_WIDTH(DATA_WIDTH), .REPETITION(REPETITION)) u_rd_check (
    .block_i(mem_q[read_address_i]), .error_o(rd_err));
  repetition_checker #(.DATA_WIDTH(DATA_WIDTH), .REPETITION(REPETITION)) u_scrub_check (
    .block_i(scrub_block_q), .error_o(scrub_err));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (scrub_enable_i && interval_q == INTERVAL_LAST) state_d = SCRUB_READ;
      SCRUB_READ:  if (!user_wr && !read_enable_i) state_d = SCRUB_CHECK;
      SCRUB_CHECK: state_d = scrub_err ? SCRUB_WRITE : IDLE;
      SCRUB_WRITE: if (stale_now || !user_wr) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    latch_en = (state_q == SCRUB_READ) && !user_wr && !read_enable_i;
    wb_en    = (state_q == SCRUB_WRITE) && !stale_now && !user_wr;
    advance  = ((state_q == SCRUB_CHECK) && !scrub_err) ||
               ((state_q == SCRUB_WRITE) && (stale_now || !user_wr));
  end

  always_comb begin
    interval_d = '0;
    if (state_q == IDLE && scrub_enable_i && interval_q != INTERVAL_LAST)
      interval_d = interval_q + IW'(1);
    stale_d = 1'b0;
    if ((state_q == SCRUB_CHECK || state_q == SCRUB_WRITE) && state_d != IDLE)
      stale_d = stale_now;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      interval_q    <= '0;
      stale_q       <= 1'b0;
      scrub_addr_q  <= '0;
      scrub_block_q <= '0;
      wrap_q        <= 1'b0;
      count_q       <= '0;
    end else begin
      interval_q <= interval_d;
      stale_q    <= stale_d;
      wrap_q     <= advance && (scrub_addr_q == LAST_ADDR);
      if (latch_en) scrub_block_q <= mem_q[scrub_addr_q];
      if (advance)
        scrub_addr_q <= (scrub_addr_q == LAST_ADDR) ? '0 : scrub_addr_q + AW'(1);
      if (error_count_clear_i)    count_q <= '0;
      else if (wb_en && !(&count_q)) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q <= '0;
    end else if (inject_enable_i) begin
      mem_q[inject_address_i] <= inject_block_i;
    end else if (write_enable_i) begin
      mem_q[write_address_i] <= {REPETITION{write_data_i}};
    end else if (wb_en) begin
      mem_q[scrub_addr_q] <= {REPETITION{scrub_word}};
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      read_error_q <= 1'b0;
    end else begin
      read_valid_q <= read_enable_i;
      if (read_enable_i) begin
        read_data_q  <= rd_word;
        read_error_q <= rd_err;
      end
    end
  end

  assign read_data_o   = read_data_q;
  assign read_valid_o  = read_valid_q;
  assign read_error_o  = read_error_q;
  assign scrub_busy_o  = (state_q != IDLE);
  assign scrub_wrap_o  = wrap_q;
  assign error_count_o = count_q;

endmodule

// File: tb/tb_repetition_scrubber.sv
// Directed + randomized bench for repetition_scrubber against a word-level storage model.
module tb_repetition_scrubber;
  localparam int DW = 8, REP = 3, DEPTH = 4, SI = 4, CW = 8, AW = 2, BW = 24;

  logic clock = 0, reset = 1;
  logic write_enable = 0, read_enable = 0, inject_enable = 0, scrub_enable = 0, error_count_clear = 0;
  logic [AW-1:0] write_address = '0, read_address = '0, inject_address = '0;
  logic [DW-1:0] write_data = '0;
  logic [BW-1:0] inject_block = '0;
  logic [DW-1:0] read_data;
  logic read_valid, read_error, scrub_busy, scrub_wrap;
  logic [CW-1:0] error_count;

  repetition_scrubber #(.DATA_WIDTH(DW), .REPETITION(REP), .DEPTH(DEPTH),
                        .SCRUB_INTERVAL(SI), .COUNT_WIDTH(CW)) dut (
    .clock_i(clock), .reset_i(reset),
    .write_enable_i(write_enable), .write_address_i(write_address), .write_data_i(write_data),
    .read_enable_i(read_enable), .read_address_i(read_address),
    .read_data_o(read_data), .read_valid_o(read_valid), .read_error_o(read_error),
    .inject_enable_i(inject_enable), .inject_address_i(inject_address), .inject_block_i(inject_block),
    .scrub_enable_i(scrub_enable), .scrub_busy_o(scrub_busy), .scrub_wrap_o(scrub_wrap),
    .error_count_o(error_count), .error_count_clear_i(error_count_clear));

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  logic [BW-1:0] model [DEPTH];
  localparam logic [BW-1:0] ERR_BLK = 24'hA5A525;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] vote(input logic [BW-1:0] blk);
    logic [DW-1:0] w;
    for (int b = 0; b < DW; b++) begin
      int n = 0;
      for (int r = 0; r < REP; r++) n += int'(blk[r*DW+b]);
      w[b] = (2 * n > REP);
    end
    return w;
  endfunction

  function automatic logic flawed(input logic [BW-1:0] blk);
    for (int r = 1; r < REP; r++)
      if (blk[r*DW +: DW] != blk[DW-1:0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable = 1; write_address = a; write_data = d; step(); write_enable = 0;
    model[a] = {REP{d}};
  endtask

  task automatic do_inject(input logic [AW-1:0] a, input logic [BW-1:0] blk);
    inject_enable = 1; inject_address = a; inject_block = blk; step(); inject_enable = 0;
    model[a] = blk;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input string tag);
    read_enable = 1; read_address = a; step(); read_enable = 0;
    chk({tag, "_valid"}, 32'(read_valid), 32'(1));
    chk({tag, "_data"}, 32'(read_data), 32'(vote(model[a])));
    chk({tag, "_err"}, 32'(read_error), 32'(flawed(model[a])));
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string tag);
    int n = 0;
    while (scrub_busy !== lvl && n < bound) begin step(); n++; end
    chk(tag, 32'(scrub_busy), 32'(lvl));
  endtask

  task automatic wait_count(input logic [CW-1:0] v, input int bound, input string tag);
    int n = 0;
    while (error_count !== v && n < bound) begin step(); n++; end
    chk(tag, 32'(error_count), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_d;
    logic exp_e, exp_v, wrap_seen;
    int n;

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    step(); step();
    chk("rst_rdata", 32'(read_data), 0);
    chk("rst_rvalid", 32'(read_valid), 0);
    chk("rst_rerr", 32'(read_error), 0);
    chk("rst_busy", 32'(scrub_busy), 0);
    chk("rst_wrap", 32'(scrub_wrap), 0);
    chk("rst_count", 32'(error_count), 0);
    reset = 0; step();

    // Basic write/read and same-cycle read-old behaviour
    do_write(2'd2, 8'hA5);
    do_read(2'd2, "wr_rd");
    write_enable = 1; write_address = 2'd3; write_data = 8'h5A;
    read_enable = 1; read_address = 2'd3; step();
    write_enable = 0; read_enable = 0;
    chk("same_cycle_old", 32'(read_data), 0);
    model[3] = {REP{8'h5A}};
    do_read(2'd3, "after_wr");
    step();
    chk("no_read_valid", 32'(read_valid), 0);

    // Inject wins over a simultaneous write
    write_enable = 1; write_address = 2'd1; write_data = 8'hFF;
    inject_enable = 1; inject_address = 2'd1; inject_block = ERR_BLK; step();
    write_enable = 0; inject_enable = 0; model[1] = ERR_BLK;
    do_read(2'd1, "inject_rd");
    chk("inject_count", 32'(error_count), 0);

    // Scrub repairs address 1 and wraps after address 3
    scrub_enable = 1;
    wait_count(8'd1, 100, "scrub_fix_count");
    model[1] = {REP{8'hA5}};
    n = 0; wrap_seen = 0;
    while (!wrap_seen && n < 100) begin step(); n++; wrap_seen = scrub_wrap; end
    chk("wrap_pulse", 32'(wrap_seen), 1);
    step();
    chk("wrap_one_cycle", 32'(scrub_wrap), 0);
    chk("count_after_sweep", 32'(error_count), 1);
    scrub_enable = 0;
    wait_busy(1'b0, 20, "idle_after_sweep");
    do_read(2'd1, "scrubbed_rd");

    // Randomized user traffic with scrubbing off
    for (int i = 0; i < 120; i++) begin
      logic [DW-1:0] d, m;
      logic [BW-1:0] blk;
      write_enable = 1'($urandom % 2);
      inject_enable = ($urandom % 4 == 0);
      read_enable = 1'($urandom % 2);
      write_address = AW'($urandom); read_address = AW'($urandom); inject_address = AW'($urandom);
      d = DW'($urandom); m = DW'($urandom);
      write_data = d;
      if ($urandom % 2) blk = {REP{d}} ^ (BW'(m) << (8 * $urandom_range(0, 2)));
      else blk = BW'($urandom);
      inject_block = blk;
      exp_v = read_enable; exp_d = vote(model[read_address]); exp_e = flawed(model[read_address]);
      if (inject_enable) model[inject_address] = blk;
      else if (write_enable) model[write_address] = {REP{write_data}};
      step();
      chk("rand_valid", 32'(read_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rand_data", 32'(read_data), 32'(exp_d));
        chk("rand_err", 32'(read_error), 32'(exp_e));
      end
    end
    write_enable = 0; inject_enable = 0; read_enable = 0;
    chk("rand_no_scrub", 32'(error_count), 1);

    // Continuous reads hold the scrubber in its read state
    do_reset();
    do_inject(2'd0, ERR_BLK);
    scrub_enable = 1; read_enable = 1; read_address = 2'd2;
    for (int i = 0; i < 40; i++) step();
    chk("starved_busy", 32'(scrub_busy), 1);
    chk("starved_count", 32'(error_count), 0);
    chk("starved_rdata", 32'(read_data), 0);
    read_enable = 0;
    wait_count(8'd1, 50, "unstarved_count");
    model[0] = {REP{8'hA5}};
    scrub_enable = 0;
    wait_busy(1'b0, 20, "idle_after_starve");
    do_read(2'd0, "unstarved_rd");

    // User write during the check cycle makes the correction stale
    do_reset();
    do_inject(2'd0, ERR_BLK);
    scrub_enable = 1;
    wait_busy(1'b1, 20, "stale_enter_read");
    step();
    do_write(2'd0, 8'h3C);
    wait_busy(1'b0, 20, "stale_back_idle");
    scrub_enable = 0;
    chk("stale_count", 32'(error_count), 0);
    do_read(2'd0, "stale_rd");

    // Saturate the counter with repeated repairs
    do_reset();
    scrub_enable = 1;
    n = 0;
    while (error_count !== 8'd255 && n < 4000) begin
      inject_enable = !scrub_busy; inject_address = AW'(n); inject_block = ERR_BLK;
      step(); n++;
    end
    chk("count_reach_max", 32'(error_count), 255);
    for (int i = 0; i < 40; i++) begin
      inject_enable = !scrub_busy; inject_address = AW'(i); inject_block = ERR_BLK;
      step();
    end
    inject_enable = 0;
    chk("count_saturated", 32'(error_count), 255);
    error_count_clear = 1; step(); error_count_clear = 0;
    chk("count_cleared", 32'(error_count), 0);

    // Reset in the middle of a write-back
    scrub_enable = 0;
    wait_busy(1'b0, 20, "pre_rst_idle");
    for (int a = 0; a < DEPTH; a++) do_inject(AW'(a), ERR_BLK);
    do_read(2'd1, "pre_rst_rd");
    scrub_enable = 1;
    wait_busy(1'b1, 20, "pre_rst_read");
    step(); step();
    chk("pre_rst_busy", 32'(scrub_busy), 1);
    reset = 1; #2;
    chk("mid_rst_rdata", 32'(read_data), 0);
    chk("mid_rst_rvalid", 32'(read_valid), 0);
    chk("mid_rst_rerr", 32'(read_error), 0);
    chk("mid_rst_busy", 32'(scrub_busy), 0);
    chk("mid_rst_wrap", 32'(scrub_wrap), 0);
    chk("mid_rst_count", 32'(error_count), 0);
    scrub_enable = 0;
    step(); reset = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    do_read(2'd1, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
